alu_cmd_sequencer: RTL and testbench

Initiator-side front end for the team's combinational 4-bit ALU (alu_4bit_simple).
- Accepts operation commands over a valid/ready interface and drives operands/opcode to the ALU.
- Captures the ALU result after a programmable wait, then returns it with flags over a valid/ready response interface.
- Keeps a running accumulator so commands can chain on the previous result.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_cmd_sequencer_if.sv | 35 +++
 rtl/alu_4bit_simple.sv | 26 ++
 rtl/alu_cmd_sequencer.sv | 100 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer and the 4-bit ALU it drives.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  // Opcodes above NOR have no ALU function and are reported as illegal.
  function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_NOR;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a producer and the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 2
);
  import alu_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ALU_OP_W-1:0] cmd_opcode;
  logic [WIDTH-1:0]    cmd_a;
  logic [WIDTH-1:0]    cmd_b;
  logic                cmd_use_acc;
  logic [TAG_W-1:0]    cmd_tag;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_result;
  logic                rsp_zero;
  logic                rsp_illegal;
  logic [TAG_W-1:0]    rsp_tag;

  // Producer / consumer side.
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
  );

endinterface

// File: rtl/alu_4bit_simple.sv
// Combinational ALU: ADD, SUB, AND, OR, NOR; undefined opcodes yield zero.
module alu_4bit_simple
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] opcode,
  output logic [WIDTH-1:0]    result
);

  // Pure function of the operands; results wrap modulo 2^WIDTH.
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front end for the combinational ALU: takes one command at a time, drives the
// ALU, samples its result after ALU_LAT extra cycles, returns it with flags and
// keeps a running accumulator for chained commands.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TAG_W   = 2,
  parameter int ALU_LAT = 0   // legal 0..3
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_opcode,
  input  logic [WIDTH-1:0]    alu_result,
  output logic [WIDTH-1:0]    acc_value,
  output logic                busy
);

  localparam logic [1:0] LAT_INIT = 2'(ALU_LAT);

  seq_state_e       state;
  logic [1:0]       wcnt;
  logic [WIDTH-1:0] acc;
  logic             ill_q;
  logic [TAG_W-1:0] tag_q;

  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_illegal_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // Ready depends on state alone so the producer never sees a loop through cmd_valid.
  assign bus.cmd_ready   = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign acc_value       = acc;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.rsp_tag     = rsp_tag_q;

  // Sequencer FSM: accept -> wait ALU_LAT+1 cycles -> hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wcnt          <= '0;
      acc           <= '0;
      ill_q         <= 1'b0;
      tag_q         <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_tag_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            // Accumulator read here already reflects a write from the previous handshake.
            alu_a      <= bus.cmd_use_acc ? acc : bus.cmd_a;
            alu_b      <= bus.cmd_b;
            alu_opcode <= bus.cmd_opcode;
            ill_q      <= op_illegal(bus.cmd_opcode);
            tag_q      <= bus.cmd_tag;
            wcnt       <= LAT_INIT;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            rsp_result_q  <= ill_q ? '0 : alu_result;
            rsp_zero_q    <= ill_q || (alu_result == '0);
            rsp_illegal_q <= ill_q;
            rsp_tag_q     <= tag_q;
            rsp_valid_q   <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            if (!rsp_illegal_q) acc <= rsp_result_q;
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a cycle-level reference model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(W), .TAG_W(TW)) bus0 ();
  alu_cmd_sequencer_if #(.WIDTH(W), .TAG_W(TW)) bus1 ();

  logic [W-1:0] alu_a0, alu_b0, alu_r0, acc0;
  logic [W-1:0] alu_a1, alu_b1, alu_r1, acc1;
  logic [2:0]   alu_op0, alu_op1;
  logic         busy0, busy1;

  alu_cmd_sequencer #(.WIDTH(W), .TAG_W(TW), .ALU_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_opcode(alu_op0), .alu_result(alu_r0),
    .acc_value(acc0), .busy(busy0));
  alu_4bit_simple #(.WIDTH(W)) u_alu0 (.a(alu_a0), .b(alu_b0), .opcode(alu_op0), .result(alu_r0));

  alu_cmd_sequencer #(.WIDTH(W), .TAG_W(TW), .ALU_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_op1), .alu_result(alu_r1),
    .acc_value(acc1), .busy(busy1));
  alu_4bit_simple #(.WIDTH(W)) u_alu1 (.a(alu_a1), .b(alu_b1), .opcode(alu_op1), .result(alu_r1));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model for dut0 (ALU_LAT = 0) ----------------
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(a) - int'(b) + 16;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = 15 - int'(a | b);
      default: r = 0;
    endcase
    return W'(r % 16);
  endfunction

  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [W-1:0] m_acc = '0, m_a = '0, m_b = '0, m_res = '0;
  logic [2:0] m_op  = '0;
  logic       m_ill = 1'b0;
  logic [TW-1:0] m_tag = '0;

  // Model: a command occupies the sequencer from acceptance until its response
  // is taken; the response is visible from two cycles after acceptance.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_acc = '0; m_a = '0; m_b = '0; m_op = '0;
    end else if (!m_active) begin
      if (bus0.cmd_valid) begin
        m_active = 1'b1;
        m_t   = cyc;
        m_a   = bus0.cmd_use_acc ? m_acc : bus0.cmd_a;
        m_b   = bus0.cmd_b;
        m_op  = bus0.cmd_opcode;
        m_ill = (bus0.cmd_opcode >= 3'd5);
        m_res = m_ill ? '0 : ref_alu(m_op, m_a, m_b);
        m_tag = bus0.cmd_tag;
      end
    end else if (cyc >= m_t + 2 && bus0.rsp_ready) begin
      m_active = 1'b0;
      if (!m_ill) m_acc = m_res;
    end
    cyc++;
  end

  // Every-cycle comparison of dut0 against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic ev;
        ev = m_active && (cyc >= m_t + 2);
        chk("cmd_ready", bus0.cmd_ready, !m_active);
        chk("busy", busy0, m_active);
        chk("rsp_valid", bus0.rsp_valid, ev);
        if (ev) begin
          chk("rsp_result", bus0.rsp_result, m_res);
          chk("rsp_zero", bus0.rsp_zero, m_res == '0);
          chk("rsp_illegal", bus0.rsp_illegal, m_ill);
          chk("rsp_tag", bus0.rsp_tag, m_tag);
        end
        chk("acc_value", acc0, m_acc);
        chk("alu_a", alu_a0, m_a);
        chk("alu_b", alu_b0, m_b);
        chk("alu_opcode", alu_op0, m_op);
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send0(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ua, input logic [TW-1:0] tag, output int t);
    t = -1;
    bus0.cmd_opcode = op; bus0.cmd_a = a; bus0.cmd_b = b;
    bus0.cmd_use_acc = ua; bus0.cmd_tag = tag; bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus0.cmd_ready) begin t = cyc; break; end
      @(negedge clk);
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no cmd_ready expected acceptance within 20 cycles");
    end
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp0(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus0.rsp_valid) begin t = cyc; break; end
      @(negedge clk);
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 20 cycles");
    end
  endtask

  task automatic take0();
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tr, t1;
    bus0.cmd_valid = 0; bus0.cmd_opcode = 0; bus0.cmd_a = 0; bus0.cmd_b = 0;
    bus0.cmd_use_acc = 0; bus0.cmd_tag = 0; bus0.rsp_ready = 0;
    bus1.cmd_valid = 0; bus1.cmd_opcode = 0; bus1.cmd_a = 0; bus1.cmd_b = 0;
    bus1.cmd_use_acc = 0; bus1.cmd_tag = 0; bus1.rsp_ready = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    // reset state, literal
    chk("rst_cmd_ready", bus0.cmd_ready, 1);
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_rsp_result", bus0.rsp_result, 0);
    chk("rst_rsp_tag", bus0.rsp_tag, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_alu_a", alu_a0, 0);
    chk("rst_alu_op", alu_op0, 0);
    chk("rst_busy1", busy1, 0);

    // ADD 7+9 wraps to 0
    send0(ALU_ADD, 4'h7, 4'h9, 1'b0, 2'd1, t);
    wait_rsp0(tr);
    chk("add_latency", tr - t, 2);
    chk("add_result", bus0.rsp_result, 4'h0);
    chk("add_zero", bus0.rsp_zero, 1);
    chk("add_tag", bus0.rsp_tag, 1);
    take0();
    chk("add_acc", acc0, 4'h0);

    // SUB 3-5, then chained SUB acc-4 (cmd_a must be ignored)
    send0(ALU_SUB, 4'h3, 4'h5, 1'b0, 2'd2, t);
    wait_rsp0(tr);
    chk("sub_result", bus0.rsp_result, 4'hE);
    chk("sub_zero", bus0.rsp_zero, 0);
    take0();
    send0(ALU_SUB, 4'hF, 4'h4, 1'b1, 2'd3, t);
    chk("chain_alu_a", alu_a0, 4'hE);
    wait_rsp0(tr);
    chk("chain_result", bus0.rsp_result, 4'hA);
    take0();
    chk("chain_acc", acc0, 4'hA);

    // illegal opcode leaves the accumulator alone
    send0(3'b110, 4'h5, 4'h5, 1'b0, 2'd0, t);
    wait_rsp0(tr);
    chk("ill_flag", bus0.rsp_illegal, 1);
    chk("ill_result", bus0.rsp_result, 0);
    chk("ill_zero", bus0.rsp_zero, 1);
    take0();
    chk("ill_acc", acc0, 4'hA);

    // NOR with a 5-cycle consumer stall and a command held meanwhile
    send0(ALU_NOR, 4'h3, 4'h4, 1'b0, 2'd1, t);
    wait_rsp0(tr);
    bus0.cmd_opcode = ALU_ADD; bus0.cmd_a = 4'h0; bus0.cmd_b = 4'h1;
    bus0.cmd_use_acc = 1'b1; bus0.cmd_tag = 2'd3; bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus0.rsp_valid, 1);
      chk("stall_result", bus0.rsp_result, 4'h8);
      chk("stall_ready", bus0.cmd_ready, 0);
      @(negedge clk);
    end
    take0();
    chk("post_hs_ready", bus0.cmd_ready, 1);
    chk("post_hs_acc", acc0, 4'h8);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    chk("held_alu_a", alu_a0, 4'h8);
    wait_rsp0(tr);
    chk("held_result", bus0.rsp_result, 4'h9);
    take0();

    // rsp_ready while idle has no effect
    bus0.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus0.rsp_ready = 1'b0;

    // reset during ISSUE abandons the operation
    send0(ALU_OR, 4'h1, 4'h2, 1'b0, 2'd2, t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", bus0.cmd_ready, 1);
    chk("abort_valid", bus0.rsp_valid, 0);
    chk("abort_acc", acc0, 0);
    repeat (3) @(negedge clk);
    send0(ALU_ADD, 4'h1, 4'h1, 1'b0, 2'd0, t);
    wait_rsp0(tr);
    chk("after_abort_result", bus0.rsp_result, 4'h2);
    take0();

    // ALU_LAT = 3 instance: AND 0xC & 0xA
    bus1.cmd_opcode = ALU_AND; bus1.cmd_a = 4'hC; bus1.cmd_b = 4'hA;
    bus1.cmd_use_acc = 1'b0; bus1.cmd_tag = 2'd2; bus1.cmd_valid = 1'b1;
    chk("lat3_ready", bus1.cmd_ready, 1);
    t1 = cyc;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    tr = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus1.rsp_valid) begin tr = cyc; break; end
      chk("lat3_busy", busy1, 1);
      @(negedge clk);
    end
    chk("lat3_latency", tr - t1, 5);
    chk("lat3_result", bus1.rsp_result, 4'h8);
    chk("lat3_tag", bus1.rsp_tag, 2);
    chk("lat3_alu_a", alu_a1, 4'hC);
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    chk("lat3_acc", acc1, 4'h8);
    chk("lat3_idle", bus1.cmd_ready, 1);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
